// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit bus CPU: opcodes, T-state encoding and control-word bit map.
package cpu_pkg;

   localparam int unsigned OPW   = 4;
   localparam int unsigned NUM_T = 5;
   localparam int unsigned CW    = 15;
   localparam int unsigned TW    = 3;

   localparam logic [OPW-1:0] OP_NOP = 4'h0;
   localparam logic [OPW-1:0] OP_LDA = 4'h1;
   localparam logic [OPW-1:0] OP_ADD = 4'h2;
   localparam logic [OPW-1:0] OP_SUB = 4'h3;
   localparam logic [OPW-1:0] OP_STA = 4'h4;
   localparam logic [OPW-1:0] OP_LDI = 4'h5;
   localparam logic [OPW-1:0] OP_JMP = 4'h6;
   localparam logic [OPW-1:0] OP_JC  = 4'h7;
   localparam logic [OPW-1:0] OP_JZ  = 4'h8;
   localparam logic [OPW-1:0] OP_OUT = 4'hE;
   localparam logic [OPW-1:0] OP_HLT = 4'hF;

   typedef enum logic [TW-1:0] {
      T0 = 3'd0,
      T1 = 3'd1,
      T2 = 3'd2,
      T3 = 3'd3,
      T4 = 3'd4
   } tstate_e;

   localparam int unsigned B_PC_INC   = 0;
   localparam int unsigned B_PC_RD    = 1;
   localparam int unsigned B_PC_WR    = 2;
   localparam int unsigned B_MAR_WR   = 3;
   localparam int unsigned B_RAM_RD   = 4;
   localparam int unsigned B_RAM_WR   = 5;
   localparam int unsigned B_IR_WR    = 6;
   localparam int unsigned B_IR_RD    = 7;
   localparam int unsigned B_A_WR     = 8;
   localparam int unsigned B_A_RD     = 9;
   localparam int unsigned B_B_WR     = 10;
   localparam int unsigned B_ALU_RD   = 11;
   localparam int unsigned B_ALU_SUB  = 12;
   localparam int unsigned B_OUT_WR   = 13;
   localparam int unsigned B_FLAGS_WR = 14;

   // One-hot control-word mask for a single strobe.
   function automatic logic [CW-1:0] cbit(input int unsigned idx);
      return CW'(1) << idx;
   endfunction

endpackage

// File: rtl/ctrl_sequencer_if.sv
// Sequencer-facing bundle: decoded inputs from IR/flags, strobes and status out.
interface ctrl_sequencer_if;
   import cpu_pkg::*;

   logic [OPW-1:0] opcode;
   logic           flag_c;
   logic           flag_z;
   logic [CW-1:0]  ctrl;
   logic           hlt;
   logic [TW-1:0]  tstate;

   modport master (
      input  opcode, flag_c, flag_z,
      output ctrl, hlt, tstate
   );

   modport slave (
      output opcode, flag_c, flag_z,
      input  ctrl, hlt, tstate
   );
endinterface

// File: rtl/ctrl_sequencer_tstate_counter.sv
// T-state counter 0..NUM_T-1 with synchronous return to T0 and a hold for the halted state.
module tstate_counter
   import cpu_pkg::*;
(
   input  logic          clk,
   input  logic          clr,
   input  logic          done,
   input  logic          hold,
   output logic [TW-1:0] tstate
);

   logic [TW-1:0] tstate_q;
   logic [TW-1:0] tstate_d;

   // Out-of-range values always fall back to T0 so the sequencer self-recovers.
   always_comb begin
      tstate_d = tstate_q + TW'(1);
      if (done || (tstate_q >= TW'(NUM_T - 1))) begin
         tstate_d = '0;
      end else if (hold) begin
         tstate_d = tstate_q;
      end
   end

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         tstate_q <= '0;
      end else begin
         tstate_q <= tstate_d;
      end
   end

   assign tstate = tstate_q;

endmodule

// File: rtl/ctrl_sequencer.sv
// Control sequencer: steps T-states, decodes the IR opcode and drives register strobes.
module ctrl_sequencer
   import cpu_pkg::*;
(
   input  logic              clk,
   input  logic              clr,
   ctrl_sequencer_if.master  bus
);

   logic [TW-1:0] tstate;
   logic          halted_q;
   logic          halted_d;
   logic [CW-1:0] ctrl_c;
   logic          done_c;
   logic          hlt_now_c;
   logic          hold_c;

   tstate_counter u_tstate_counter (
      .clk    (clk),
      .clr    (clr),
      .done   (done_c),
      .hold   (hold_c),
      .tstate (tstate)
   );

   // Decode of {opcode, tstate}; done_c marks the last active state of each instruction.
   always_comb begin
      ctrl_c    = '0;
      done_c    = 1'b0;
      hlt_now_c = 1'b0;
      if (!halted_q) begin
         case (tstate)
            T0: ctrl_c = cbit(B_PC_RD) | cbit(B_MAR_WR);
            T1: ctrl_c = cbit(B_RAM_RD) | cbit(B_IR_WR) | cbit(B_PC_INC);
            T2: begin
               case (bus.opcode)
                  OP_LDA, OP_ADD, OP_SUB, OP_STA: ctrl_c = cbit(B_IR_RD) | cbit(B_MAR_WR);
                  OP_LDI: begin
                     ctrl_c = cbit(B_IR_RD) | cbit(B_A_WR);
                     done_c = 1'b1;
                  end
                  OP_JMP: begin
                     ctrl_c = cbit(B_IR_RD) | cbit(B_PC_WR);
                     done_c = 1'b1;
                  end
                  OP_JC: begin
                     if (bus.flag_c) ctrl_c = cbit(B_IR_RD) | cbit(B_PC_WR);
                     done_c = 1'b1;
                  end
                  OP_JZ: begin
                     if (bus.flag_z) ctrl_c = cbit(B_IR_RD) | cbit(B_PC_WR);
                     done_c = 1'b1;
                  end
                  OP_OUT: begin
                     ctrl_c = cbit(B_A_RD) | cbit(B_OUT_WR);
                     done_c = 1'b1;
                  end
                  OP_HLT: hlt_now_c = 1'b1;
                  default: done_c = 1'b1;
               endcase
            end
            T3: begin
               case (bus.opcode)
                  OP_LDA: begin
                     ctrl_c = cbit(B_RAM_RD) | cbit(B_A_WR);
                     done_c = 1'b1;
                  end
                  OP_ADD, OP_SUB: ctrl_c = cbit(B_RAM_RD) | cbit(B_B_WR);
                  OP_STA: begin
                     ctrl_c = cbit(B_A_RD) | cbit(B_RAM_WR);
                     done_c = 1'b1;
                  end
                  default: done_c = 1'b1;
               endcase
            end
            T4: begin
               case (bus.opcode)
                  OP_ADD: ctrl_c = cbit(B_ALU_RD) | cbit(B_A_WR) | cbit(B_FLAGS_WR);
                  OP_SUB: ctrl_c = cbit(B_ALU_RD) | cbit(B_A_WR) | cbit(B_FLAGS_WR)
                                 | cbit(B_ALU_SUB);
                  default: ctrl_c = '0;
               endcase
               done_c = 1'b1;
            end
            default: done_c = 1'b1;
         endcase
      end
   end

   assign hold_c   = halted_q | hlt_now_c;
   assign halted_d = halted_q | hlt_now_c;

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         halted_q <= 1'b0;
      end else begin
         halted_q <= halted_d;
      end
   end

   // clr gates the strobes immediately, ahead of the async state reset settling.
   assign bus.ctrl   = clr ? '0 : ctrl_c;
   assign bus.hlt    = clr ? 1'b0 : hold_c;
   assign bus.tstate = tstate;

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Scoreboard bench for ctrl_sequencer: stimulus queues expected per-cycle outputs, monitor compares.
module tb_ctrl_sequencer;
   import cpu_pkg::*;

   logic clk;
   logic clr;

   ctrl_sequencer_if bus ();

   ctrl_sequencer dut (
      .clk (clk),
      .clr (clr),
      .bus (bus)
   );

   typedef struct {
      logic [18:0] v;
      string       name;
   } exp_t;

   exp_t sb_q[$];
   int   total = 0;
   int   bad   = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Hand-derived control words per opcode and T-state.
   function automatic logic [14:0] model_ctrl(input logic [3:0] op, input int t,
                                              input logic fc, input logic fz);
      if (t == 0) return 15'h000A;
      if (t == 1) return 15'h0051;
      case (op)
         4'h1: return (t == 2) ? 15'h0088 : 15'h0110;
         4'h2: return (t == 2) ? 15'h0088 : (t == 3) ? 15'h0410 : 15'h4900;
         4'h3: return (t == 2) ? 15'h0088 : (t == 3) ? 15'h0410 : 15'h5900;
         4'h4: return (t == 2) ? 15'h0088 : 15'h0220;
         4'h5: return 15'h0180;
         4'h6: return 15'h0084;
         4'h7: return fc ? 15'h0084 : 15'h0000;
         4'h8: return fz ? 15'h0084 : 15'h0000;
         4'hE: return 15'h2200;
         default: return 15'h0000;
      endcase
   endfunction

   function automatic int model_len(input logic [3:0] op);
      case (op)
         4'h1, 4'h4: return 4;
         4'h2, 4'h3: return 5;
         default:    return 3;
      endcase
   endfunction

   task automatic expect_cycle(input logic [14:0] c, input logic h, input logic [2:0] t,
                               input string name);
      exp_t e;
      e.v    = {h, t, c};
      e.name = name;
      sb_q.push_back(e);
      @(posedge clk);
      #1;
   endtask

   task automatic run_instr(input logic [3:0] op, input logic fc, input logic fz);
      bus.opcode = op;
      bus.flag_c = fc;
      bus.flag_z = fz;
      for (int t = 0; t < model_len(op); t++) begin
         expect_cycle(model_ctrl(op, t, fc, fz), 1'b0, 3'(t),
                      $sformatf("op%0h_t%0d_c%0d_z%0d", op, t, fc, fz));
      end
   endtask

   task automatic check_cleared(input string tag);
      check({tag, "_ctrl"}, 32'(bus.ctrl), 32'h0);
      check({tag, "_hlt"}, 32'(bus.hlt), 32'h0);
      check({tag, "_tstate"}, 32'(bus.tstate), 32'h0);
   endtask

   // Monitor: every cycle the DUT presents a control word; compare against the queue head.
   always @(negedge clk) begin
      exp_t e;
      if (!clr) begin
         check("bus_onehot", 32'($countones(bus.ctrl & 15'h0A92) <= 1), 32'd1);
      end
      if (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         check(e.name, 32'({bus.hlt, bus.tstate, bus.ctrl}), 32'(e.v));
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      clr        = 1'b1;
      bus.opcode = 4'h0;
      bus.flag_c = 1'b0;
      bus.flag_z = 1'b0;
      #3;
      check_cleared("reset");
      @(posedge clk);
      #1;
      clr = 1'b0;

      // Fetch + NOP, arithmetic, conditional jumps both ways, remaining ops.
      run_instr(4'h0, 1'b0, 1'b0);
      run_instr(4'h2, 1'b0, 1'b0);
      run_instr(4'h3, 1'b1, 1'b0);
      run_instr(4'h7, 1'b1, 1'b0);
      run_instr(4'h7, 1'b0, 1'b1);
      run_instr(4'h8, 1'b0, 1'b1);
      run_instr(4'h8, 1'b1, 1'b0);
      run_instr(4'h1, 1'b0, 1'b0);
      run_instr(4'h4, 1'b0, 1'b0);
      run_instr(4'h5, 1'b0, 1'b0);
      run_instr(4'h6, 1'b0, 1'b0);
      run_instr(4'hE, 1'b0, 1'b0);

      // clr asserted mid-cycle during LDA T3.
      bus.opcode = 4'h1;
      expect_cycle(15'h000A, 1'b0, 3'd0, "lda_mid_t0");
      expect_cycle(15'h0051, 1'b0, 3'd1, "lda_mid_t1");
      expect_cycle(15'h0088, 1'b0, 3'd2, "lda_mid_t2");
      #2;
      check("lda_mid_t3_ctrl", 32'(bus.ctrl), 32'h0110);
      clr = 1'b1;
      #1;
      check_cleared("midop_clr");
      @(posedge clk);
      #1;
      clr = 1'b0;
      run_instr(4'h1, 1'b0, 1'b0);

      // Halt: hlt from T2, frozen for 20 cycles even if the opcode changes.
      bus.opcode = 4'hF;
      expect_cycle(15'h000A, 1'b0, 3'd0, "hlt_t0");
      expect_cycle(15'h0051, 1'b0, 3'd1, "hlt_t1");
      expect_cycle(15'h0000, 1'b1, 3'd2, "hlt_t2");
      bus.opcode = 4'h2;
      repeat (20) expect_cycle(15'h0000, 1'b1, 3'd2, "halted_hold");
      clr = 1'b1;
      #1;
      check_cleared("halt_clr");
      @(posedge clk);
      #1;
      clr = 1'b0;
      run_instr(4'h0, 1'b0, 1'b0);

      // Sweep every non-halting opcode against all flag combinations.
      for (int op = 0; op < 15; op++) begin
         for (int f = 0; f < 4; f++) begin
            run_instr(4'(op), f[0], f[1]);
         end
      end
      expect_cycle(15'h000A, 1'b0, 3'd0, "final_t0");

      for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(negedge clk);
      check("sb_drain", 32'(sb_q.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
